// File: rtl/lms_fir_engine_pkg.sv
// rtl/lms_fir_engine_pkg.sv - lms_pkg: FSM states, Q1.15 limits and saturation helpers.
// Shared by the LMS FIR engine top and its tap MAC.
package lms_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int     FRAC_DEF = 15;
  localparam longint Q15_MAX  = 64'sd32767;
  localparam longint Q15_MIN  = -64'sd32768;
  localparam longint Q31_MAX  = 64'sd2147483647;
  localparam longint Q31_MIN  = -64'sd2147483648;

  function automatic logic signed [15:0] sat16(input logic signed [63:0] v);
    if (v > Q15_MAX) return 16'sh7fff;
    if (v < Q15_MIN) return 16'sh8000;
    return v[15:0];
  endfunction

  function automatic logic signed [31:0] sat32(input logic signed [63:0] v);
    if (v > Q31_MAX) return 32'sh7fff_ffff;
    if (v < Q31_MIN) return 32'sh8000_0000;
    return v[31:0];
  endfunction

endpackage

// File: rtl/lms_fir_engine_if.sv
// rtl/lms_fir_engine_if.sv - start/sample/result handshake between the ANC core and the LMS FIR engine.
// The core drives the master side; the engine takes the slave side.
interface lms_fir_engine_if;

  logic               fir_go;
  logic signed [31:0] sample_in;
  logic signed [31:0] weight_adjust;
  logic signed [31:0] fir_out;
  logic               fir_done;
  logic               busy;

  modport master (
    output fir_go, sample_in, weight_adjust,
    input  fir_out, fir_done, busy
  );

  modport slave (
    input  fir_go, sample_in, weight_adjust,
    output fir_out, fir_done, busy
  );

endinterface

// File: rtl/lms_fir_engine_tap_mac.sv
// rtl/lms_fir_engine_tap_mac.sv - combinational single-tap MAC and LMS weight update (leaky form under LMS_LEAK_EN).
// The engine time-multiplexes this one instance over all taps.
module lms_tap_mac
  import lms_pkg::*;
#(
  parameter int ACC_W = 40,
  parameter int FRAC  = FRAC_DEF
`ifdef LMS_LEAK_EN
  ,
  parameter int LEAK_SHIFT = 10
`endif
) (
  input  logic signed [15:0]      w_i,
  input  logic signed [15:0]      x_i,
  input  logic signed [15:0]      mue_i,
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [ACC_W-1:0] acc_o,
  output logic signed [15:0]      w_o
);

  logic signed [31:0] prod;
  logic signed [31:0] adj;
  logic signed [63:0] w_sum;

  assign prod  = 32'(w_i) * 32'(x_i);
  assign adj   = (32'(mue_i) * 32'(x_i)) >>> FRAC;
  assign acc_o = acc_i + ACC_W'(prod);

`ifdef LMS_LEAK_EN
  // Leak term pulls every weight slowly toward zero before the gradient step.
  assign w_sum = 64'(w_i) - 64'(w_i >>> LEAK_SHIFT) + 64'(adj);
`else
  assign w_sum = 64'(w_i) + 64'(adj);
`endif

  assign w_o = sat16(w_sum);

endmodule

// File: rtl/lms_fir_engine.sv
// rtl/lms_fir_engine.sv - adaptive LMS FIR stage, one tap per cycle; LMS_LEAK_EN selects leaky adaptation.
// Accepts fir_go in IDLE only and pulses fir_done TAPS+1 cycles later.
module lms_fir_engine
  import lms_pkg::*;
#(
  parameter int TAPS  = 16,
  parameter int FRAC  = FRAC_DEF,
  parameter int ACC_W = 40
`ifdef LMS_LEAK_EN
  ,
  parameter int LEAK_SHIFT = 10
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  lms_fir_engine_if.slave   bus
);

  localparam int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;

  state_e                   state_q;
  logic [IDX_W-1:0]         idx_q;
  logic signed [15:0]       x_q [TAPS];
  logic signed [15:0]       w_q [TAPS];
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [15:0]       mue_q;
  logic signed [31:0]       fir_out_q;
  logic                     fir_done_q;
  logic                     busy_q;

  logic signed [ACC_W-1:0]  acc_d;
  logic signed [15:0]       w_d;

  lms_tap_mac #(
    .ACC_W      (ACC_W),
    .FRAC       (FRAC)
`ifdef LMS_LEAK_EN
    ,
    .LEAK_SHIFT (LEAK_SHIFT)
`endif
  ) u_tap_mac (
    .w_i   (w_q[idx_q]),
    .x_i   (x_q[idx_q]),
    .mue_i (mue_q),
    .acc_i (acc_q),
    .acc_o (acc_d),
    .w_o   (w_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      acc_q      <= '0;
      mue_q      <= '0;
      fir_out_q  <= '0;
      fir_done_q <= 1'b0;
      busy_q     <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        x_q[i] <= '0;
        w_q[i] <= '0;
      end
    end else begin
      fir_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.fir_go) begin
            for (int i = TAPS - 1; i > 0; i--) begin
              x_q[i] <= x_q[i-1];
            end
            x_q[0]  <= sat16(64'(bus.sample_in));
            mue_q   <= sat16(64'(bus.weight_adjust >>> FRAC));
            acc_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= MAC;
          end
        end
        MAC: begin
          acc_q      <= acc_d;
          w_q[idx_q] <= w_d;
          // The last tap's sum goes straight to the output so fir_done lands in the DONE cycle.
          if (idx_q == IDX_W'(TAPS - 1)) begin
            fir_out_q  <= sat32(64'(acc_d >>> FRAC));
            fir_done_q <= 1'b1;
            state_q    <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.fir_out  = fir_out_q;
  assign bus.fir_done = fir_done_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_lms_fir_engine.sv
// tb/tb_lms_fir_engine.sv - randomized self-checking bench for lms_fir_engine against an arithmetic LMS model.
module tb_lms_fir_engine;

  localparam int TAPS = 16;
  localparam int LAT  = TAPS + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  lms_fir_engine_if bus ();

  lms_fir_engine #(
    .TAPS  (TAPS),
    .FRAC  (15),
    .ACC_W (40)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  longint mx [TAPS];
  longint mw [TAPS];
  longint m_out;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint m_sat(input longint v, input longint lo, input longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic longint m_sat16(input longint v);
    return m_sat(v, -32768, 32767);
  endfunction

  function automatic longint m_sat32(input longint v);
    return m_sat(v, -64'sd2147483648, 64'sd2147483647);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < TAPS; i++) begin
      mx[i] = 0;
      mw[i] = 0;
    end
    m_out = 0;
  endtask

  task automatic model_go(input int s, input int wa);
    longint mue, acc;
    for (int i = TAPS - 1; i > 0; i--) mx[i] = mx[i-1];
    mx[0] = m_sat16(longint'(s));
    mue   = m_sat16(longint'(wa) >>> 15);
    acc   = 0;
    for (int i = 0; i < TAPS; i++) begin
      acc += mw[i] * mx[i];
`ifdef LMS_LEAK_EN
      mw[i] = m_sat16(mw[i] - (mw[i] >>> 10) + ((mue * mx[i]) >>> 15));
`else
      mw[i] = m_sat16(mw[i] + ((mue * mx[i]) >>> 15));
`endif
    end
    m_out = m_sat32(acc >>> 15);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // inject: extra fir_go pulses during MAC and in the DONE cycle, both must be ignored.
  task automatic run_pass(input int s, input int wa, input bit inject, input string tag);
    int lat;
    int stray;
    @(negedge clk);
    bus.fir_go        = 1'b1;
    bus.sample_in     = s;
    bus.weight_adjust = wa;
    model_go(s, wa);
    @(negedge clk);
    bus.fir_go = 1'b0;
    lat = 1;
    check($sformatf("%s_busy_start", tag), bus.busy, 1);
    while (bus.fir_done !== 1'b1 && lat < 40) begin
      bus.fir_go = inject && (lat == 5);
      if (inject) bus.sample_in = 32'sd1234;
      @(negedge clk);
      lat++;
    end
    bus.fir_go = 1'b0;
    check($sformatf("%s_latency", tag), lat, LAT);
    check($sformatf("%s_fir_out", tag), bus.fir_out, m_out);
    check($sformatf("%s_busy_done", tag), bus.busy, 1);
    if (inject) bus.fir_go = 1'b1;
    @(negedge clk);
    bus.fir_go = 1'b0;
    check($sformatf("%s_done_pulse", tag), bus.fir_done, 0);
    check($sformatf("%s_busy_end", tag), bus.busy, 0);
    if (inject) begin
      stray = 0;
      repeat (LAT + 4) begin
        @(negedge clk);
        if (bus.fir_done || bus.busy) stray++;
      end
      check($sformatf("%s_no_restart", tag), stray, 0);
    end
  endtask

  task automatic abort_pass(input int s, input int wa);
    int stray;
    @(negedge clk);
    bus.fir_go        = 1'b1;
    bus.sample_in     = s;
    bus.weight_adjust = wa;
    @(negedge clk);
    bus.fir_go = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("abort_fir_out", bus.fir_out, 0);
    check("abort_busy", bus.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (bus.fir_done) stray++;
    end
    check("abort_no_done", stray, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, wa;
    bus.fir_go        = 1'b0;
    bus.sample_in     = '0;
    bus.weight_adjust = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_fir_out", bus.fir_out, 0);
    check("reset_fir_done", bus.fir_done, 0);
    check("reset_busy", bus.busy, 0);
    rst_n = 1'b1;

    run_pass(16384, 0, 1'b0, "zero_w");
    check("zero_w_const", bus.fir_out, 0);
    run_pass(16384, 0, 1'b0, "zero_w2");

    do_reset();
    run_pass(32767, 1 << 29, 1'b0, "adapt1");
    run_pass(32767, 1 << 29, 1'b0, "adapt2");
    check("adapt2_const", bus.fir_out, 16382);
    for (int i = 0; i < 5; i++) run_pass(32767, 1 << 29, 1'b0, $sformatf("wsat%0d", i));

    run_pass(32'sh0001_2345, 1 << 29, 1'b0, "in_sat_pos");
    run_pass(int'(32'hFFFE_0000), 1 << 29, 1'b0, "in_sat_neg");
    run_pass(-20000, -(1 << 28), 1'b0, "in_neg");

    run_pass(12000, 1 << 27, 1'b1, "ignore_go");
    run_pass(-7000, 1 << 27, 1'b0, "after_ignore");

    abort_pass(30000, 1 << 29);
    run_pass(25000, 1 << 29, 1'b0, "post_abort1");
    run_pass(-25000, 1 << 29, 1'b0, "post_abort2");

    for (int i = 0; i < 24; i++) begin
      s  = int'($urandom) >>> $urandom_range(0, 17);
      wa = int'($urandom) >>> $urandom_range(0, 6);
      run_pass(s, wa, ($urandom_range(0, 5) == 0), $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
